nms_frame_sequencer: RTL
========================

# nms_frame_sequencer

Frame-level scheduler for the non-maximum-suppression stage. After a `start` pulse it walks every interior pixel of a gradient-magnitude frame in raster order and fetches the 3x3 neighbourhood through a single-outstanding memory read port. It presents each completed window, with its centre address, to the NMS datapath over a valid/ready handshake. It sits between the frame buffer and the per-pixel NMS controller/datapath, and supplies the `refAddr` sequence that the per-pixel controller consumes.

## Interface
- `IMG_W`, default 30: frame width in pixels, must be ≥3.
- `IMG_H`, default 30: frame height in pixels, must be ≥3.
- `ADDR_W`, default 15: frame-buffer address width; IMG_W*IMG_H ≤ 2^ADDR_W.
- `DATA_W`, default 8: magnitude sample width.
- `clock` in, 1 bit: single clock; all state changes on the rising edge.
- `nReset` in, 1 bit: reset, asynchronous, active-low.
- `start` in, 1 bit: begin frame; sampled only in IDLE.
- `busy` out, 1 bit: frame in progress.
- `done` out, 1 bit: one-cycle pulse after the last window is accepted.
- `memReq` out, 1 bit: read request.
- `memAddr` out, ADDR_W bits: read address; stable while `memReq` is high.
- `memAck` in, 1 bit: read complete; `memData` is valid in the same cycle.
- `memData` in, DATA_W bits: read data.
- `winValid` out, 1 bit: window available.
- `winReady` in, 1 bit: datapath accepts the window.
- `winAddr` out, ADDR_W bits: centre pixel address (`refAddr` for the downstream controller).
- `winData` out, 9*DATA_W bits: neighbourhood, slot k at bits [k*DATA_W +: DATA_W].

## Operation
- Slot numbering k=0..8 is row-major NW,N,NE,W,C,E,SW,S,SE. It matches the adjacency numbering 0..8 of the per-pixel NMS controller.
- Slot offsets from the centre: −W−1, −W, −W+1, −1, 0, +1, W−1, W, W+1, where W=IMG_W.
- Only interior pixels are scheduled: rows 1..IMG_H−2, columns 1..IMG_W−2. Border pixels produce no window.
- Windows per frame: (IMG_W−2)*(IMG_H−2). The default frame produces 784.
- The centre address is kept incrementally, with no multiplier:
  - It starts at IMG_W+1.
  - It advances +1 within a row and +3 at the end of a row (column IMG_W−2 to column 1 of the next row).
  - The last centre is (IMG_H−2)*IMG_W + IMG_W−2.
- State machine:
  - IDLE: `start`=1 → FETCH. Centre is set to IMG_W+1 and k to 0.
  - FETCH: `memReq`=1, `memAddr`=centre+offset[k]. On `memAck`, `memData` is stored in slot k. If k=8 → PRESENT; otherwise k+1.
  - PRESENT: `winValid`=1. On `winReady`: if the centre is the last one → DONE; otherwise advance the centre, set k=0, and go to FETCH.
  - DONE: `done`=1 for one cycle → IDLE.
- `winData` and `winAddr` hold stable while `winValid`=1 and `winReady`=0.
- `start` is ignored outside IDLE. A `start` held high through DONE begins a new frame on the first IDLE cycle.
- Asserting `nReset` mid-frame aborts the frame immediately: no `done`, no further requests.

## Timing
- Reset values: state IDLE; `busy`, `done`, `memReq`, `winValid` all 0; `memAddr`, `winAddr`, `winData` all 0.
- `busy`=1 in FETCH and PRESENT, and 0 in IDLE and DONE.
- The first `memReq` is asserted in the cycle after `start` is sampled, with `memAddr`=0.
- One outstanding read at a time. The next request is issued in the cycle after `memAck`. Back-to-back reads are allowed when `memAck` is tied high.
- Minimum per-pixel latency is 10 cycles: 9 FETCH cycles plus 1 PRESENT cycle, with zero-wait memory and `winReady` held high.
- `done` is asserted in the cycle after the final `winValid && winReady` handshake.
- `memAck` while `memReq`=0 is ignored.

## Structure
- Package `nms_pkg` holds:
  - the state enum (IDLE, FETCH, PRESENT, DONE);
  - slot index constants NB_NW..NB_SE (0..8);
  - the `NB_COUNT`=9 constant.
- Sub-module `nms_addr_gen` holds the centre address, row/column counters, the last-pixel flag and the neighbour address mux. It has inputs `init` and `advance` and `k`, and outputs `centre`, `nbAddr` and `last`.
- The top level holds the FSM and the 9-slot window register.

## Test plan
- 5x5 frame, memory returns addr[7:0], zero-wait: first window has centre 6 and slots 0,1,2,5,6,7,10,11,12. Exactly 9 windows are produced, with the last centre at 18, and `done` pulses once.
- 3x3 frame: exactly one window with centre 4 and slots 0..8, followed by `done`.
- Random 0–4 cycle `memAck` delay: `memAddr` is stable until acknowledged, and the window contents are identical to the zero-wait run.
- `winReady` held low for 5 cycles in PRESENT: `winValid`, `winAddr` and `winData` stay stable, and no `memReq` is issued.
- `start` pulsed during FETCH: ignored, and the window count is unchanged.
- `nReset` asserted during FETCH of window 4: all outputs are 0 immediately. A subsequent `start` restarts at `memAddr` 0 with a full window count.

Source files
------------

// File: rtl/nms_pkg.sv
// Shared types and constants for the NMS frame sequencer.
// No logic; consumed by the sequencer top and its address generator.
// Slot numbering matches the per-pixel NMS controller adjacency order.
package nms_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef logic [3:0] slot_t;

  // Row-major 3x3 neighbourhood slots: NW,N,NE,W,C,E,SW,S,SE
  localparam slot_t NB_NW = 4'd0;
  localparam slot_t NB_N  = 4'd1;
  localparam slot_t NB_NE = 4'd2;
  localparam slot_t NB_W  = 4'd3;
  localparam slot_t NB_C  = 4'd4;
  localparam slot_t NB_E  = 4'd5;
  localparam slot_t NB_SW = 4'd6;
  localparam slot_t NB_S  = 4'd7;
  localparam slot_t NB_SE = 4'd8;

  localparam int NB_COUNT = 9;

endpackage

// File: rtl/nms_addr_gen.sv
// Purpose: interior-pixel centre address walker plus 3x3 neighbour address mux.
// Latency: centre updates one cycle after init/advance; nbAddr/last are combinational.
// Backpressure: none internally; the caller only pulses advance on an accepted window.
module nms_addr_gen
  import nms_pkg::*;
#(
  parameter int IMG_W  = 30,
  parameter int IMG_H  = 30,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              init,
  input  logic              advance,
  input  slot_t             k,
  output logic [ADDR_W-1:0] centre,
  output logic [ADDR_W-1:0] nbAddr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] THREE_A  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 2);

  logic [ADDR_W-1:0] centre_q, centre_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;

  // Centre/row/col registers
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      centre_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      centre_q <= centre_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  // Incremental walk: +1 along a row, +3 to skip the right and left border pixels
  always_comb begin
    centre_d = centre_q;
    col_d    = col_q;
    row_d    = row_q;
    if (init) begin
      centre_d = FIRST_A;
      col_d    = ONE_A;
      row_d    = ONE_A;
    end else if (advance) begin
      if (col_q == LAST_COL) begin
        centre_d = centre_q + THREE_A;
        col_d    = ONE_A;
        row_d    = row_q + ONE_A;
      end else begin
        centre_d = centre_q + ONE_A;
        col_d    = col_q + ONE_A;
      end
    end
  end

  // Neighbour address for the slot currently being fetched
  always_comb begin
    nbAddr = centre_q;
    case (k)
      NB_NW:   nbAddr = centre_q - W_A - ONE_A;
      NB_N:    nbAddr = centre_q - W_A;
      NB_NE:   nbAddr = centre_q - W_A + ONE_A;
      NB_W:    nbAddr = centre_q - ONE_A;
      NB_C:    nbAddr = centre_q;
      NB_E:    nbAddr = centre_q + ONE_A;
      NB_SW:   nbAddr = centre_q + W_A - ONE_A;
      NB_S:    nbAddr = centre_q + W_A;
      NB_SE:   nbAddr = centre_q + W_A + ONE_A;
      default: nbAddr = centre_q;
    endcase
  end

  assign centre = centre_q;
  assign last   = (row_q == LAST_ROW) && (col_q == LAST_COL);

endmodule

// File: rtl/nms_frame_sequencer.sv
// Purpose: walks interior pixels, fetches each 3x3 window via one-outstanding reads, hands it downstream.
// Latency: 9 FETCH cycles + 1 PRESENT cycle per pixel with zero-wait memory and winReady high.
// Backpressure: window and centre held in PRESENT until winReady; no reads are issued meanwhile.
module nms_frame_sequencer
  import nms_pkg::*;
#(
  parameter int IMG_W  = 30,
  parameter int IMG_H  = 30,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   memReq,
  output logic [ADDR_W-1:0]      memAddr,
  input  logic                   memAck,
  input  logic [DATA_W-1:0]      memData,
  output logic                   winValid,
  input  logic                   winReady,
  output logic [ADDR_W-1:0]      winAddr,
  output logic [9*DATA_W-1:0]    winData
);

  state_e                  state_q, state_d;
  slot_t                   k_q, k_d;
  logic [9*DATA_W-1:0]     win_q, win_d;
  logic [ADDR_W-1:0]       centre;
  logic [ADDR_W-1:0]       nb_addr;
  logic                    last;
  logic                    init;
  logic                    advance;

  assign init    = (state_q == IDLE) && start;
  assign advance = (state_q == PRESENT) && winReady && !last;

  nms_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock   (clock),
    .nReset  (nReset),
    .init    (init),
    .advance (advance),
    .k       (k_q),
    .centre  (centre),
    .nbAddr  (nb_addr),
    .last    (last)
  );

  // State, slot index and window registers
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      k_q     <= NB_NW;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      win_q   <= win_d;
    end
  end

  // Next-state: memAck only counts while a read is outstanding (FETCH)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (memAck && (k_q == NB_SE)) state_d = PRESENT;
      PRESENT: if (winReady) state_d = last ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slot index and window capture
  always_comb begin
    k_d   = k_q;
    win_d = win_q;
    case (state_q)
      IDLE: if (start) k_d = NB_NW;
      FETCH: begin
        if (memAck) begin
          win_d[int'(k_q)*DATA_W +: DATA_W] = memData;
          if (k_q != NB_SE) k_d = k_q + slot_t'(1);
        end
      end
      PRESENT: if (winReady) k_d = NB_NW;
      default: k_d = k_q;
    endcase
  end

  // Outputs decoded from state; addresses forced to 0 outside their valid phase
  always_comb begin
    busy     = (state_q == FETCH) || (state_q == PRESENT);
    done     = (state_q == DONE);
    memReq   = (state_q == FETCH);
    memAddr  = (state_q == FETCH) ? nb_addr : '0;
    winValid = (state_q == PRESENT);
    winAddr  = (state_q == PRESENT) ? centre : '0;
    winData  = win_q;
  end

endmodule
